matrix_tx_formatter: RTL and testbench
======================================

// Module: matrix_tx_formatter
// PURPOSE
//  Prints one stored matrix as ASCII text over the UART transmit path; the output-side counterpart of the UART matrix input parser.
//  Reads elements row-major from Matrix_storage, converts each to unsigned decimal, emits "e e e\r\n" per row as a byte stream.
//  Sits between the storage mux (read port) and the byte-level UART transmitter; started by FSM_Controller.
// PARAMETERS
//  ADDR_W  8   storage address width
//  DATA_W  32  storage word width
//  VAL_W   16  low bits of each word printed (unsigned); upper bits ignored
//  DIM_W   3   width of row/column counts (legal 0..5)
//  NDIG    5   max decimal digits = ceil(VAL_W*log10(2))
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, active-high
//  i_start     in   1       1-cycle start pulse; sampled only in IDLE
//  i_base_addr in   ADDR_W  address of element (0,0)
//  i_m         in   DIM_W   row count, latched at start
//  i_n         in   DIM_W   column count, latched at start
//  o_rd_en     out  1       storage read strobe
//  o_rd_addr   out  ADDR_W  storage read address
//  i_rd_data   in   DATA_W  storage data, valid 1 cycle after o_rd_en
//  o_tx_data   out  8       ASCII byte to UART TX
//  o_tx_valid  out  1       byte valid
//  i_tx_ready  in   1       UART TX can accept; transfer when valid&&ready
//  o_busy      out  1       high from accepted start until done
//  o_done      out  1       1-cycle pulse after last byte transferred
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, FSM -> IDLE, counters cleared; no partial byte survives.
//  - FSM: IDLE -> RD_REQ -> RD_WAIT -> CONV -> EMIT_DIG -> {EMIT_SP -> RD_REQ | EMIT_CR -> EMIT_LF -> RD_REQ | DONE} -> IDLE.
//  - IDLE: i_start latches base, m, n; o_busy=1 next cycle. i_start outside IDLE ignored.
//  - m==0 or n==0: IDLE -> DONE directly; o_done pulses 2 cycles after start, zero bytes sent.
//  - RD_REQ: o_rd_en=1 one cycle, o_rd_addr = base + r*n + c (mod 2^ADDR_W, wraps). RD_WAIT captures i_rd_data[VAL_W-1:0].
//  - CONV: sequential double-dabble, exactly VAL_W cycles, yields NDIG BCD digits.
//  - EMIT_DIG: leading zeros suppressed, most significant first; value 0 prints single '0'. Digit byte = 8'h30 + bcd.
//  - Separators: ' ' (8'h20) between columns; after last column of a row "\r\n" (8'h0D, 8'h0A); no trailing space.
//  - Handshake: o_tx_valid asserted with o_tx_data; both held stable until i_tx_ready sampled high; advance only on transfer.
//    o_tx_valid may stay high back-to-back; never drops without a transfer except on reset.
//  - After LF of row m-1 -> DONE: o_done=1 one cycle, o_busy=0 same cycle, then IDLE; next start accepted the following cycle.
//  - No read is issued while a byte is pending; o_rd_en and o_tx_valid never both high.
//  - i_rd_data only sampled in RD_WAIT; storage contents changing mid-print affect only unread elements.
// STRUCTURE
//  - Shared package: ASCII constants (CH_0, CH_SP, CH_CR, CH_LF), FSM state enum, NDIG function of VAL_W.
//  - One sub-module: bin2bcd_seq (start/done, VAL_W-cycle double-dabble, NDIG x 4-bit BCD out).
//  - Address generation: row base accumulator (+n per row) plus column counter; no multiplier.
// TESTING
//  - 2x3 at base 8'h10, words 1..6 -> bytes "1 2 3\r\n4 5 6\r\n" (14 bytes), reads 8'h10..8'h15 in order, one o_done.
//  - 1x2 words 32'h0000_0000, 32'hABCD_FFFF -> "0 65535\r\n"; upper 16 bits ignored.
//  - i_tx_ready low 10 cycles mid-digit -> o_tx_valid/o_tx_data unchanged all 10 cycles, no byte lost or duplicated.
//  - i_start pulsed while busy -> ignored, output identical to single-start run; m=0,n=4 -> no bytes, o_done 2 cycles after start.
//  - Base 8'hFE, 1x3 -> reads 8'hFE, 8'hFF, 8'h00 (wrap).
//  - rst asserted mid-row -> next edge all outputs 0; fresh start afterwards prints full matrix from (0,0).

Source files
------------

// File: rtl/matrix_tx_formatter_pkg.sv
// Shared definitions for the matrix text formatter: ASCII bytes, FSM states
// and the decimal digit count needed for a given printed value width.
package matrix_tx_formatter_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CONV,
        ST_EMIT_DIG,
        ST_EMIT_SP,
        ST_EMIT_CR,
        ST_EMIT_LF,
        ST_DONE
    } state_t;

    // Number of decimal digits of the largest val_w-bit value, which equals
    // ceil(val_w * log10(2)) for every val_w >= 1.
    function automatic int calc_ndig(input int val_w);
        longint unsigned lim;
        longint unsigned p;
        int              d;
        lim = (64'd1 << val_w) - 64'd1;
        d   = 1;
        p   = 64'd10;
        while (p <= lim) begin
            d++;
            p = p * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/matrix_tx_formatter_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, VAL_W cycles per
// conversion. The BCD result holds until the next start.
module bin2bcd_seq
    import matrix_tx_formatter_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int NDIG  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [VAL_W-1:0]    bin,
    output logic                done,
    output logic [NDIG*4-1:0]   bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic [NDIG*4-1:0] adj;
    logic              unused_top;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[i*4 +: 4] > 4'd4) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // The top adjusted bit shifts out; it is always 0 for a correctly sized NDIG.
    assign unused_top = adj[NDIG*4-1];

    // Load on start, then shift one bit per cycle under a down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (start) begin
            shreg <= bin;
            bcd   <= '0;
            cnt   <= CNT_W'(VAL_W);
            done  <= 1'b0;
        end else if (cnt != '0) begin
            bcd   <= {adj[NDIG*4-2:0], shreg[VAL_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt - CNT_W'(1);
            done  <= (cnt == CNT_W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/matrix_tx_formatter.sv
// Prints an m x n matrix from storage as ASCII decimal text, row-major,
// "e e e\r\n" per row, over a valid/ready byte stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// RD_REQ     | storage read strobe high for one cycle
// RD_WAIT    | read data valid; converter loads it
// CONV       | double-dabble running
// EMIT_DIG   | digit byte offered, most significant non-zero digit first
// EMIT_SP    | column separator offered
// EMIT_CR    | end-of-row CR offered
// EMIT_LF    | end-of-row LF offered
// DONE       | final cycle; done pulse and busy drop follow
module matrix_tx_formatter
    import matrix_tx_formatter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int VAL_W  = 16,
    parameter int DIM_W  = 3,
    parameter int NDIG   = calc_ndig(VAL_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [DIM_W-1:0]  i_m,
    input  logic [DIM_W-1:0]  i_n,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0]  m_q;
    logic [DIM_W-1:0]  n_q;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [IDX_W-1:0]  dig_idx;
    logic [IDX_W-1:0]  lead_idx;
    logic              conv_start;
    logic              conv_done;
    logic [NDIG*4-1:0] bcd;
    logic              unused_hi;

    // Only the low VAL_W bits of a storage word are printed.
    assign unused_hi  = ^i_rd_data[DATA_W-1:VAL_W];
    assign conv_start = (state == ST_RD_WAIT);

    bin2bcd_seq #(
        .VAL_W (VAL_W),
        .NDIG  (NDIG)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (i_rd_data[VAL_W-1:0]),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Highest non-zero digit; stays 0 for a zero value so a single '0' prints.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                lead_idx = IDX_W'(i);
            end
        end
    end

    function automatic logic [7:0] dig_char(input logic [NDIG*4-1:0] b,
                                            input logic [IDX_W-1:0]  idx);
        logic [7:0] c;
        c = CH_0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                c = CH_0 + {4'd0, b[i*4 +: 4]};
            end
        end
        return c;
    endfunction

    // Sequencer with registered outputs; the read strobe and address are set on
    // entry to RD_REQ, and a byte only advances on a valid/ready transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            row_base   <= '0;
            m_q        <= '0;
            n_q        <= '0;
            row        <= '0;
            col        <= '0;
            dig_idx    <= '0;
            o_rd_en    <= 1'b0;
            o_rd_addr  <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        m_q      <= i_m;
                        n_q      <= i_n;
                        row      <= '0;
                        col      <= '0;
                        row_base <= i_base_addr;
                        o_busy   <= 1'b1;
                        if (i_m == '0 || i_n == '0) begin
                            state <= ST_DONE;
                        end else begin
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= i_base_addr;
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    o_rd_en <= 1'b0;
                    state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        dig_idx    <= lead_idx;
                        o_tx_data  <= dig_char(bcd, lead_idx);
                        o_tx_valid <= 1'b1;
                        state      <= ST_EMIT_DIG;
                    end
                end
                ST_EMIT_DIG: begin
                    if (i_tx_ready) begin
                        if (dig_idx != '0) begin
                            dig_idx   <= dig_idx - IDX_W'(1);
                            o_tx_data <= dig_char(bcd, dig_idx - IDX_W'(1));
                        end else if (col == n_q - DIM_W'(1)) begin
                            o_tx_data <= CH_CR;
                            state     <= ST_EMIT_CR;
                        end else begin
                            o_tx_data <= CH_SP;
                            state     <= ST_EMIT_SP;
                        end
                    end
                end
                ST_EMIT_SP: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        col        <= col + DIM_W'(1);
                        o_rd_en    <= 1'b1;
                        o_rd_addr  <= row_base + ADDR_W'(col) + ADDR_W'(1);
                        state      <= ST_RD_REQ;
                    end
                end
                ST_EMIT_CR: begin
                    if (i_tx_ready) begin
                        o_tx_data <= CH_LF;
                        state     <= ST_EMIT_LF;
                    end
                end
                ST_EMIT_LF: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        if (row == m_q - DIM_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            row       <= row + DIM_W'(1);
                            col       <= '0;
                            row_base  <= row_base + ADDR_W'(n_q);
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= row_base + ADDR_W'(n_q);
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Directed bench for matrix_tx_formatter: storage model, byte/read monitor,
// and literal expected text for each scenario.
module tb_matrix_tx_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base_addr = '0;
    logic [2:0]  i_m = '0;
    logic [2:0]  i_n = '0;
    logic        o_rd_en;
    logic [7:0]  o_rd_addr;
    logic [31:0] i_rd_data = '0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;

    matrix_tx_formatter dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_m         (i_m),
        .i_n         (i_n),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [7:0]  byte_q [$];
    logic [7:0]  addr_q [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_at_done = 0;
    int          viol = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Storage returns data one cycle after the read strobe.
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observe transfers, reads and done away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_valid && i_tx_ready) byte_q.push_back(o_tx_data);
            if (o_rd_en) addr_q.push_back(o_rd_addr);
            if (o_rd_en && o_tx_valid) viol++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = int'(o_busy);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic pulse_start(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n);
        @(posedge clk); #1;
        i_base_addr = base;
        i_m = m;
        i_n = n;
        i_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_no_overlap"}, 32'(viol), 32'd0);
    endtask

    task automatic chk_bytes(input string tag, input string exp);
        chk({tag, "_len"}, 32'(byte_q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < byte_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(byte_q[i]), 32'(exp.getc(i)));
        end
    endtask

    task automatic chk_addrs(input string tag, input logic [7:0] first, input int cnt);
        logic [7:0] a;
        a = first;
        chk({tag, "_nreads"}, 32'(addr_q.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < addr_q.size(); i++) begin
            chk($sformatf("%s_a%0d", tag, i), 32'(addr_q[i]), 32'(a));
            a = a + 8'd1;
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
        chk({tag, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 6; i++) mem[8'h10 + i] = 32'(i + 1);
        mem[8'h20] = 32'h0000_0000;
        mem[8'h21] = 32'hABCD_FFFF;
        mem[8'h30] = 32'd12345;
        mem[8'hFE] = 32'd7;
        mem[8'hFF] = 32'd8;
        mem[8'h00] = 32'd9;

        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 2x3 with a second start while busy, which must be ignored.
        clear_mon();
        pulse_start(8'h10, 3'd2, 3'd3);
        chk("m2x3_busy", 32'(o_busy), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        i_base_addr = 8'h00;
        i_m = 3'd1;
        i_n = 3'd1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done("m2x3");
        chk_bytes("m2x3", "1 2 3\r\n4 5 6\r\n");
        chk_addrs("m2x3", 8'h10, 6);

        // Zero value and upper bits ignored.
        clear_mon();
        pulse_start(8'h20, 3'd1, 3'd2);
        wait_done("m1x2");
        chk_bytes("m1x2", "0 65535\r\n");
        chk_addrs("m1x2", 8'h20, 2);

        // Stall ready for 10 cycles while the middle digit is offered.
        clear_mon();
        pulse_start(8'h30, 3'd1, 3'd1);
        k = 0;
        while (!(o_tx_valid && o_tx_data == 8'h33) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stall_reached", 32'(o_tx_valid && o_tx_data == 8'h33), 32'd1);
        i_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid%0d", i), 32'(o_tx_valid), 32'd1);
            chk($sformatf("stall_data%0d", i), 32'(o_tx_data), 32'h33);
        end
        @(posedge clk); #1;
        i_tx_ready = 1'b1;
        wait_done("stall");
        chk_bytes("stall", "12345\r\n");

        // Empty matrix: no bytes, no reads, done two cycles after start.
        clear_mon();
        pulse_start(8'h40, 3'd0, 3'd4);
        wait_done("m0");
        chk("m0_done_cyc", 32'(done_cyc - start_cyc), 32'd2);
        chk("m0_nbytes", 32'(byte_q.size()), 32'd0);
        chk("m0_nreads", 32'(addr_q.size()), 32'd0);

        // Address wrap past the top of storage.
        clear_mon();
        pulse_start(8'hFE, 3'd1, 3'd3);
        wait_done("wrap");
        chk_bytes("wrap", "7 8 9\r\n");
        chk_addrs("wrap", 8'hFE, 3);

        // Reset mid-row, then a fresh full print.
        clear_mon();
        pulse_start(8'h10, 3'd2, 3'd3);
        k = 0;
        while (byte_q.size() < 3 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("rstmid_reached", 32'(byte_q.size() >= 3), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_outs_zero("rstmid");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        pulse_start(8'h10, 3'd2, 3'd3);
        wait_done("rerun");
        chk_bytes("rerun", "1 2 3\r\n4 5 6\r\n");
        chk_addrs("rerun", 8'h10, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
